// File: rtl/bsg_nonsynth_dram_channel_responder_pkg.sv
// Shared types and helpers for the fixed-latency DRAM channel responder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package bsg_nonsynth_dram_channel_responder_pkg;

    // Widest channel address the pipeline entry can carry; narrower addresses are zero-extended.
    localparam int max_ch_addr_width_lp = 64;

    typedef struct packed {
        logic                            v;
        logic                            write_not_read;
        logic [max_ch_addr_width_lp-1:0] ch_addr;
    } dram_resp_pipe_s;

    // Byte address to word index: drop the byte offset inside a DRAM word.
    // The caller truncates the result to the number of backed index bits.
    function automatic logic [max_ch_addr_width_lp-1:0] word_index(
        input logic [max_ch_addr_width_lp-1:0] ch_addr,
        input int unsigned                     lg_data_bytes_lp
    );
        return ch_addr >> lg_data_bytes_lp;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small generic one-read one-write FIFO with registered occupancy count.
// Latency: an entry written at edge t is visible on v_o/data_o from t onward (one cycle).
// Backpressure: ready_o drops when full; no same-cycle bypass when full and dequeuing.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                enq, deq;

    assign ready_o = (count_r != cnt_w_lp'(els_p));
    assign v_o     = (count_r != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_r[rptr_r];

    // Pointers wrap at els_p, which need not be a power of two.
    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= next_ptr(wptr_r);
            if (deq) rptr_r <= next_ptr(rptr_r);
            count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_nonsynth_dram_channel_responder_wfifo.sv
// Pending write-command queue: holds accepted write addresses until their data arrives.
// Latency: an address enqueued in cycle t can be dequeued in cycle t+1 at the earliest.
// Backpressure: full_o stalls further write commands; dequeue only when non-empty.
module bsg_nonsynth_dram_channel_responder_wfifo #(
    parameter int els_p   = 4,
    parameter int width_p = 29
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_addr_i,
    output logic               full_o,
    output logic               deq_v_o,
    output logic [width_p-1:0] deq_addr_o,
    input  logic               deq_i
);
    logic ready;

    bsg_fifo_1r1w_small #(
        .width_p (width_p),
        .els_p   (els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq_v_i),
        .data_i  (enq_addr_i),
        .ready_o (ready),
        .v_o     (deq_v_o),
        .data_o  (deq_addr_o),
        .yumi_i  (deq_i)
    );

    assign full_o = ~ready;

`ifndef SYNTHESIS
    overflow_chk: assert property (@(posedge clk_i) disable iff (reset_i) !(enq_v_i && full_o))
        else $error("wfifo overflow");
    underflow_chk: assert property (@(posedge clk_i) disable iff (reset_i) !(deq_i && !deq_v_o))
        else $error("wfifo underflow");
`endif

endmodule

// File: rtl/bsg_nonsynth_dram_channel_responder.sv
// Fixed-latency single-channel DRAM model: zero-initialised word array, in-order write data pairing.
// Latency: read data returns read_latency_p cycles after acceptance; write_done one cycle after commit.
// Backpressure: reads never stall; writes stall while the pending-command queue is full; no read backpressure.
module bsg_nonsynth_dram_channel_responder
    import bsg_nonsynth_dram_channel_responder_pkg::*;
#(
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 256,
    parameter int mem_addr_width_p     = 10,
    parameter int read_latency_p       = 8,
    parameter int wcmd_els_p           = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            v_i,
    input  logic                            write_not_read_i,
    input  logic [channel_addr_width_p-1:0] ch_addr_i,
    output logic                            yumi_o,
    input  logic                            data_v_i,
    input  logic [data_width_p-1:0]         data_i,
    output logic                            data_yumi_o,
    output logic                            data_v_o,
    output logic [data_width_p-1:0]         data_o,
    output logic [channel_addr_width_p-1:0] read_done_ch_addr_o,
    output logic                            write_done_o,
    output logic [channel_addr_width_p-1:0] write_done_ch_addr_o
);
    localparam int unsigned lg_data_bytes_lp = $clog2(data_width_p / 8);
    localparam int          mem_els_lp       = 1 << mem_addr_width_p;
    localparam int          stages_lp        = read_latency_p - 1;

    if (channel_addr_width_p > max_ch_addr_width_lp) begin : g_bad_width
        $error("channel_addr_width_p exceeds pipeline entry width");
    end

    logic                            wfifo_full, wfifo_v;
    logic [channel_addr_width_p-1:0] wfifo_addr;
    logic [mem_addr_width_p-1:0]     wr_idx, rd_idx;
    logic                            rd_fire;
    logic [data_width_p-1:0]         mem_r [mem_els_lp];
    dram_resp_pipe_s                 pipe_r [stages_lp];
    dram_resp_pipe_s                 last;

    assign yumi_o      = v_i & ~reset_i & (~write_not_read_i | ~wfifo_full);
    assign data_yumi_o = data_v_i & wfifo_v;

    bsg_nonsynth_dram_channel_responder_wfifo #(
        .els_p   (wcmd_els_p),
        .width_p (channel_addr_width_p)
    ) wfifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enq_v_i    (yumi_o & write_not_read_i),
        .enq_addr_i (ch_addr_i),
        .full_o     (wfifo_full),
        .deq_v_o    (wfifo_v),
        .deq_addr_o (wfifo_addr),
        .deq_i      (data_yumi_o)
    );

    assign last    = pipe_r[stages_lp-1];
    assign rd_fire = last.v & ~last.write_not_read;
    assign wr_idx  = mem_addr_width_p'(word_index(max_ch_addr_width_lp'(wfifo_addr), lg_data_bytes_lp));
    assign rd_idx  = mem_addr_width_p'(word_index(last.ch_addr, lg_data_bytes_lp));

    // Every accepted command enters the delay line; only reads act at its end.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < stages_lp; i++) pipe_r[i] <= '0;
        end else begin
            pipe_r[0] <= '{v: yumi_o, write_not_read: write_not_read_i,
                           ch_addr: max_ch_addr_width_lp'(ch_addr_i)};
            for (int i = 1; i < stages_lp; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    // Memory sample for the oldest read happens before this edge's write commit lands.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < mem_els_lp; i++) mem_r[i] <= '0;
            data_v_o            <= 1'b0;
            data_o              <= '0;
            read_done_ch_addr_o <= '0;
        end else begin
            data_v_o <= rd_fire;
            if (rd_fire) begin
                data_o              <= mem_r[rd_idx];
                read_done_ch_addr_o <= channel_addr_width_p'(last.ch_addr);
            end
            if (data_yumi_o) mem_r[wr_idx] <= data_i;
        end
    end

    // Report each committed write one cycle after its data is consumed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            write_done_o         <= 1'b0;
            write_done_ch_addr_o <= '0;
        end else begin
            write_done_o <= data_yumi_o;
            if (data_yumi_o) write_done_ch_addr_o <= wfifo_addr;
        end
    end

`ifndef SYNTHESIS
    addr_known_chk: assert property (@(posedge clk_i) disable iff (reset_i) v_i |-> !$isunknown(ch_addr_i))
        else $error("ch_addr_i has X while v_i is high");
`ifdef BSG_DRAM_RESP_DEBUG
    // Trace every accepted command.
    always @(posedge clk_i) begin
        if (yumi_o) $display("dram_resp: %s addr=%h", write_not_read_i ? "WR" : "RD", ch_addr_i);
    end
`endif
`endif

endmodule

// File: tb/tb_bsg_nonsynth_dram_channel_responder.sv
module tb_bsg_nonsynth_dram_channel_responder;
    localparam int AW = 29;
    localparam int DW = 256;
    localparam int MW = 10;
    localparam int L  = 8;
    localparam int WC = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          v_i = 1'b0, write_not_read_i = 1'b0;
    logic [AW-1:0] ch_addr_i = '0;
    logic          yumi_o;
    logic          data_v_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          data_yumi_o, data_v_o, write_done_o;
    logic [DW-1:0] data_o;
    logic [AW-1:0] read_done_ch_addr_o, write_done_ch_addr_o;

    always #5 clk = ~clk;

    bsg_nonsynth_dram_channel_responder #(
        .channel_addr_width_p (AW),
        .data_width_p         (DW),
        .mem_addr_width_p     (MW),
        .read_latency_p       (L),
        .wcmd_els_p           (WC)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .v_i                  (v_i),
        .write_not_read_i     (write_not_read_i),
        .ch_addr_i            (ch_addr_i),
        .yumi_o               (yumi_o),
        .data_v_i             (data_v_i),
        .data_i               (data_i),
        .data_yumi_o          (data_yumi_o),
        .data_v_o             (data_v_o),
        .data_o               (data_o),
        .read_done_ch_addr_o  (read_done_ch_addr_o),
        .write_done_o         (write_done_o),
        .write_done_ch_addr_o (write_done_ch_addr_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [DW-1:0] d; logic [AW-1:0] a; } rexp_t;
    typedef struct { int due; logic [AW-1:0] a; } wexp_t;
    typedef struct { int smp; logic [AW-1:0] a; } rfly_t;

    logic [DW-1:0] mem_m [1 << MW];
    logic [AW-1:0] pend[$];
    rfly_t         rfly[$];
    rexp_t         rexp_q[$];
    wexp_t         wexp_q[$];
    logic          m_ey, m_edy;
    logic [AW-1:0] m_a;
    rfly_t         m_r;

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a / (DW / 8)) % (1 << MW);
    endfunction

    // Model: one evaluation per cycle; the read sample sees memory before this cycle's commit.
    always @(negedge clk) begin
        if (reset_i) begin
            pend.delete(); rfly.delete(); rexp_q.delete(); wexp_q.delete();
            for (int i = 0; i < (1 << MW); i++) mem_m[i] = '0;
            chk("yumi_in_reset", DW'(yumi_o), '0);
        end else begin
            m_ey  = v_i && (!write_not_read_i || pend.size() < WC);
            m_edy = data_v_i && pend.size() > 0;
            chk("cmd_yumi", DW'(yumi_o), DW'(m_ey));
            chk("data_yumi", DW'(data_yumi_o), DW'(m_edy));
            while (rfly.size() > 0 && rfly[0].smp == cyc) begin
                m_r = rfly.pop_front();
                rexp_q.push_back('{cyc + 1, mem_m[widx(m_r.a)], m_r.a});
            end
            if (m_edy) begin
                m_a = pend.pop_front();
                mem_m[widx(m_a)] = data_i;
                wexp_q.push_back('{cyc + 1, m_a});
            end
            if (m_ey) begin
                if (write_not_read_i) pend.push_back(ch_addr_i);
                else rfly.push_back('{cyc + L - 1, ch_addr_i});
            end
        end
    end

    // ---------------- monitor ----------------
    rexp_t mr;
    wexp_t mw;
    always @(negedge clk) begin
        if (!reset_i) begin
            if (data_v_o) begin
                if (rexp_q.size() == 0) chk("unexpected_data_v", DW'(data_v_o), '0);
                else begin
                    mr = rexp_q.pop_front();
                    chk("read_cycle", DW'(cyc), DW'(mr.due));
                    chk("read_data", data_o, mr.d);
                    chk("read_addr", DW'(read_done_ch_addr_o), DW'(mr.a));
                end
            end else if (rexp_q.size() > 0 && rexp_q[0].due <= cyc) begin
                mr = rexp_q.pop_front();
                chk("missing_data_v", DW'(data_v_o), DW'(1));
            end
            if (write_done_o) begin
                if (wexp_q.size() == 0) chk("unexpected_write_done", DW'(write_done_o), '0);
                else begin
                    mw = wexp_q.pop_front();
                    chk("wdone_cycle", DW'(cyc), DW'(mw.due));
                    chk("wdone_addr", DW'(write_done_ch_addr_o), DW'(mw.a));
                end
            end else if (wexp_q.size() > 0 && wexp_q[0].due <= cyc) begin
                mw = wexp_q.pop_front();
                chk("missing_write_done", DW'(write_done_o), DW'(1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a);
        int n = 0;
        v_i = 1'b1; write_not_read_i = w; ch_addr_i = a;
        forever begin
            @(negedge clk);
            n++;
            if (yumi_o) break;
            if (n > 300) begin
                chk("cmd_timeout", DW'(yumi_o), DW'(1));
                break;
            end
        end
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d);
        int n = 0;
        data_v_i = 1'b1; data_i = d;
        forever begin
            @(negedge clk);
            n++;
            if (data_yumi_o) break;
            if (n > 300) begin
                chk("data_timeout", DW'(data_yumi_o), DW'(1));
                break;
            end
        end
        @(posedge clk); #1;
        data_v_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_yumi"}, DW'(yumi_o), '0);
        chk({tag, "_data_yumi"}, DW'(data_yumi_o), '0);
        chk({tag, "_data_v"}, DW'(data_v_o), '0);
        chk({tag, "_data"}, data_o, '0);
        chk({tag, "_rd_addr"}, DW'(read_done_ch_addr_o), '0);
        chk({tag, "_wdone"}, DW'(write_done_o), '0);
        chk({tag, "_wd_addr"}, DW'(write_done_ch_addr_o), '0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 7) * 32 + $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) a = a | AW'(1 << 15);
        return a;
    endfunction

    logic acc, dacc;

    initial begin
        #1 reset_i = 1'b1;
        #2 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        // read of untouched word returns zero
        while (cyc < 20) step(1);
        send_cmd(1'b0, AW'('h0));
        step(L + 2);

        // simple write then read back
        fork
            send_cmd(1'b1, AW'('h40));
            send_data({32{8'hA5}});
        join
        step(3);
        send_cmd(1'b0, AW'('h40));
        step(L + 2);

        // five writes against a four-deep queue, data arriving late
        fork
            for (int i = 0; i < 5; i++) send_cmd(1'b1, AW'('h100 + i * 'h40));
            begin
                step(12);
                for (int i = 0; i < 5; i++) send_data(DW'(100 + i));
            end
        join
        step(4);

        // preload sixteen words with their index, then stream reads
        fork
            for (int i = 0; i < 16; i++) send_cmd(1'b1, AW'(i * 'h40));
            for (int i = 0; i < 16; i++) send_data(DW'(i));
        join
        step(4);
        for (int i = 0; i < 16; i++) send_cmd(1'b0, AW'(i * 'h40));
        step(L + 4);

        // same-edge hazard on 0x80: old value 3, commit of 7 lands as the read samples
        fork
            send_cmd(1'b1, AW'('h80));
            send_data(DW'(3));
        join
        step(3);
        send_cmd(1'b1, AW'('h80));
        send_cmd(1'b0, AW'('h80));
        step(L - 2);
        data_v_i = 1'b1; data_i = DW'(7);
        step(1);
        data_v_i = 1'b0;
        send_cmd(1'b0, AW'('h80));
        step(L + 3);

        // randomized mixed traffic with aliased addresses
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            acc = yumi_o; dacc = data_yumi_o;
            @(posedge clk); #1;
            if (!v_i || acc) begin
                v_i = ($urandom_range(0, 2) != 0);
                write_not_read_i = 1'($urandom_range(0, 1));
                ch_addr_i = rnd_addr();
            end
            if (!data_v_i || dacc) begin
                data_v_i = 1'($urandom_range(0, 1));
                data_i = {8{$urandom()}};
            end
        end
        v_i = 1'b0;
        data_v_i = 1'b0;
        step(1);
        for (int k = 0; k < 20 && pend.size() > 0; k++) send_data({8{$urandom()}});
        step(L + 3);

        // reset with reads in flight and unpaired writes
        send_cmd(1'b1, AW'('h200));
        send_cmd(1'b1, AW'('h240));
        for (int i = 0; i < 3; i++) send_cmd(1'b0, AW'('h40 + i * 'h40));
        reset_i = 1'b1;
        #1 check_outputs_zero("midreset");
        step(2);
        reset_i = 1'b0;
        step(L + 5);
        send_cmd(1'b0, AW'('h40));
        send_cmd(1'b0, AW'('h80));
        step(L + 3);

        for (int k = 0; k < 50 && (rexp_q.size() > 0 || wexp_q.size() > 0); k++) step(1);
        if (rexp_q.size() > 0 || wexp_q.size() > 0)
            chk("drain_timeout", DW'(rexp_q.size() + wexp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_nonsynth_dram_channel_responder.md
Name: bsg_nonsynth_dram_channel_responder

Overview:
- Single-channel, fixed-latency DRAM responder for unit benches that drive the channel request interface (command, write data, read return) without launching DRAMSim3.
- Accepts read/write commands on a valid/yumi port and pairs write data in order. Stores data in a zero-initialised word array.
- Returns read data a fixed number of cycles after acceptance, with no backpressure, and reports write completion.

Parameters:
- channel_addr_width_p, 29: width of the channel byte address.
- data_width_p, 256: DRAM word width in bits; a power of 2 and at least 8.
- mem_addr_width_p, 10: number of backed word-index bits; 2^mem_addr_width_p words, with higher index bits aliased.
- read_latency_p, 8: cycles from read acceptance to data_v_o; at least 2.
- wcmd_els_p, 4: depth of the pending-write-command FIFO; at least 2.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: asynchronous, active-high reset.
- v_i, input, 1: command valid.
- write_not_read_i, input, 1: 1 = write, 0 = read.
- ch_addr_i, input, channel_addr_width_p: command byte address.
- yumi_o, output, 1: command accepted this cycle.
- data_v_i, input, 1: write data valid.
- data_i, input, data_width_p: write data.
- data_yumi_o, output, 1: write data consumed this cycle.
- data_v_o, output, 1: read data valid.
- data_o, output, data_width_p: read data.
- read_done_ch_addr_o, output, channel_addr_width_p: address of the returning read.
- write_done_o, output, 1: write committed.
- write_done_ch_addr_o, output, channel_addr_width_p: address of the committed write.

Behaviour:
- Reset: async assert clears all state immediately.
  - Outputs go to 0: yumi_o, data_yumi_o, data_v_o, data_o, read_done_ch_addr_o, write_done_o, write_done_ch_addr_o.
  - The read pipeline and write FIFO are emptied and all memory words are zeroed.
  - Reset mid-operation discards in-flight reads and unpaired write commands; nothing is returned for them.
  - No command or data is accepted while reset_i=1.
- Word index = ch_addr >> log2(data_width_p/8), truncated to mem_addr_width_p bits. The byte offset is ignored.
- yumi_o (combinational on inputs and state):
  - = v_i & ~reset_i & (~write_not_read_i | ~wfifo_full).
  - Reads are always accepted, one per cycle.
  - Writes stall while the FIFO is full.
- Write path:
  - An accepted write enqueues ch_addr into the FIFO.
  - data_yumi_o = data_v_i & ~wfifo_empty, combinational. Data arriving before its command waits.
  - On data_yumi_o, the memory word at the FIFO-head index takes data_i at the clock edge, and the head is dequeued.
  - The next cycle, write_done_o=1 for exactly one cycle, with write_done_ch_addr_o = that address.
  - Write data pairs with write commands in acceptance order.
  - A command enqueued in cycle t can pair with data at cycle t+1 at the earliest. Same-cycle pairing with an empty FIFO is not allowed.
  - FIFO full plus simultaneous dequeue: yumi_o is still 0 that cycle (no bypass).
- Read path:
  - A shift pipeline of read_latency_p-1 stages carries {valid, ch_addr}.
  - A read accepted at edge t reaches the last stage at t+L-1. The memory is sampled then and registered into data_o.
  - At t+L: data_v_o=1, with data_o and read_done_ch_addr_o valid.
  - Outputs hold their last values when data_v_o=0. data_v_o is a single-cycle pulse per read; back-to-back reads give back-to-back pulses.
- Hazard, same edge: when a write commits to a word in the same cycle the memory is sampled for a read of that word, the read returns the old value (read-before-write).
- Hazard, ordering: a read sampled after a write commit to the same word returns the new value. Ordering is by commit time, not command acceptance.
- Counters:
  - wfifo count has width $clog2(wcmd_els_p+1).
  - Head/tail pointers wrap modulo wcmd_els_p.
- Assertions (nonsynth, after reset):
  - Error on ch_addr_i having X while v_i=1.
  - Error on wfifo overflow or underflow.
  - $display of each command when debug is enabled (no parameter; compile-time `define BSG_DRAM_RESP_DEBUG).

Decomposition:
- Shared package bsg_nonsynth_dram_channel_responder_pkg:
  - dram_resp_pipe_s {v, write_not_read, ch_addr}.
  - Function word_index(ch_addr) with byte-offset constant lg_data_bytes_lp.
- One natural sub-module: the pending-write-command FIFO, using bsg_fifo_1r1w_small with els_p=wcmd_els_p, width channel_addr_width_p.
- Memory and read pipeline stay in the top module.

Test Plan:
- Reset, then read of addr 0x0 at cycle 20 with L=8 -> data_v_o=1 at cycle 28, data_o=0, read_done_ch_addr_o=0x0.
- Write 0x40 with data 0xA5 (replicated), then read 0x40 after write_done_o -> data_o=0xA5…A5 exactly L cycles after read yumi_o; write_done_ch_addr_o=0x40.
- Five write commands with data_v_i=0 and wcmd_els_p=4 -> yumi_o=1 for the first 4, 0 for the 5th. Then data_v_i=1 for 4 cycles -> 4 data_yumi_o pulses in order; the 5th command is accepted once the FIFO has space.
- 16 back-to-back reads of addresses 0x0…0x3C0 (stride 0x40, preloaded with index values) -> 16 consecutive data_v_o pulses with data_o=0…15 in order.
- Same-edge hazard: write commit to 0x80 (new value 7, old value 3) in the cycle the read of 0x80 is sampled -> the read returns 3; a following read returns 7.
- Assert reset_i with 3 reads in flight and 2 unpaired writes -> all outputs 0 immediately, no data_v_o afterward; the memory reads 0 after deassertion.
